// File: rtl/mandelbrot_raster_engine.sv
// Fixed-point Mandelbrot raster engine: iterates z = z^2 + c per pixel and streams escape counts.
// Define MANDEL_PERF_CNT_EN to add the perf_cycles output (ITER cycles per frame, saturating).
module mandelbrot_raster_engine #(
    parameter int BITWIDTH = 11,
    parameter int CTRWIDTH = 7,
    parameter int OUTWIDTH = 4,
    parameter int COLS     = 80,
    parameter int ROWS     = 60
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run,
    input  logic [CTRWIDTH-1:0] max_ctr,
    input  logic [1:0]          scaling,
    input  logic [BITWIDTH-1:0] cr_offset,
    input  logic [BITWIDTH-1:0] ci_offset,
    input  logic [1:0]          ctr_select,
    input  logic                pix_ready,
    output logic                pix_valid,
    output logic [OUTWIDTH-1:0] pix_data,
    output logic                pix_last,
    output logic                running,
    output logic                finished
`ifdef MANDEL_PERF_CNT_EN
    ,
    output logic [31:0]         perf_cycles
`endif
);

    localparam int FRAC  = BITWIDTH - 3;
    localparam int PW    = 2 * BITWIDTH + 1;
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic signed [PW-1:0] ESC_LIM = PW'(1) << (2 * FRAC + 2);

    typedef enum logic [1:0] {IDLE, ITER, OUT, DONE} state_t;

    state_t                      state;
    logic [COL_W-1:0]            col;
    logic [ROW_W-1:0]            row;
    logic signed [BITWIDTH-1:0]  zr, zi;
    logic [CTRWIDTH-1:0]         n;
    logic [CTRWIDTH-1:0]         max_ctr_q;
    logic [1:0]                  scaling_q, ctr_select_q;
    logic [BITWIDTH-1:0]         cr_offset_q, ci_offset_q;

    logic signed [BITWIDTH-1:0]  cr, ci, zr_next, zi_next;
    logic signed [PW-1:0]        zr_w, zi_w, zr_sq, zi_sq, zr_zi, mag;
    logic                        escape, at_last_col, at_last_row;

    // 2*zr*zi>>>FRAC is taken as zr*zi>>>(FRAC-1); the doubled product always fits in PW bits.
    always_comb begin
        cr          = cr_offset_q + (BITWIDTH'(col) << scaling_q);
        ci          = ci_offset_q + (BITWIDTH'(row) << scaling_q);
        zr_w        = PW'(zr);
        zi_w        = PW'(zi);
        zr_sq       = zr_w * zr_w;
        zi_sq       = zi_w * zi_w;
        zr_zi       = zr_w * zi_w;
        mag         = zr_sq + zi_sq;
        escape      = (mag >= ESC_LIM);
        zr_next     = BITWIDTH'((zr_sq - zi_sq) >>> FRAC) + cr;
        zi_next     = BITWIDTH'(zr_zi >>> (FRAC - 1)) + ci;
        at_last_col = (col == COL_W'(COLS - 1));
        at_last_row = (row == ROW_W'(ROWS - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            col          <= '0;
            row          <= '0;
            zr           <= '0;
            zi           <= '0;
            n            <= '0;
            max_ctr_q    <= '0;
            scaling_q    <= '0;
            ctr_select_q <= '0;
            cr_offset_q  <= '0;
            ci_offset_q  <= '0;
            pix_valid    <= 1'b0;
            pix_data     <= '0;
            pix_last     <= 1'b0;
            running      <= 1'b0;
            finished     <= 1'b0;
`ifdef MANDEL_PERF_CNT_EN
            perf_cycles  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (run) begin
                        max_ctr_q    <= max_ctr;
                        scaling_q    <= scaling;
                        ctr_select_q <= ctr_select;
                        cr_offset_q  <= cr_offset;
                        ci_offset_q  <= ci_offset;
                        col          <= '0;
                        row          <= '0;
                        zr           <= '0;
                        zi           <= '0;
                        n            <= '0;
                        running      <= 1'b1;
                        finished     <= 1'b0;
                        state        <= ITER;
`ifdef MANDEL_PERF_CNT_EN
                        perf_cycles  <= '0;
`endif
                    end
                end
                ITER: begin
`ifdef MANDEL_PERF_CNT_EN
                    if (perf_cycles != '1) perf_cycles <= perf_cycles + 32'd1;
`endif
                    if (!run) begin
                        running <= 1'b0;
                        state   <= IDLE;
                    end else if (escape || (n == max_ctr_q)) begin
                        pix_valid <= 1'b1;
                        pix_data  <= escape ? OUTWIDTH'(n >> ctr_select_q) : '0;
                        pix_last  <= at_last_col && at_last_row;
                        state     <= OUT;
                    end else begin
                        zr <= zr_next;
                        zi <= zi_next;
                        n  <= n + CTRWIDTH'(1);
                    end
                end
                OUT: begin
                    if (pix_ready) begin
                        pix_valid <= 1'b0;
                        pix_data  <= '0;
                        pix_last  <= 1'b0;
                        zr        <= '0;
                        zi        <= '0;
                        n         <= '0;
                        if (at_last_col) begin
                            col <= '0;
                            row <= at_last_row ? '0 : row + ROW_W'(1);
                        end else begin
                            col <= col + COL_W'(1);
                        end
                        if (pix_last) begin
                            running  <= 1'b0;
                            finished <= 1'b1;
                            state    <= DONE;
                        end else if (!run) begin
                            running <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            state <= ITER;
                        end
                    end
                end
                DONE: begin
                    if (!run) begin
                        finished <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mandelbrot_raster_engine.sv
// Directed bench for mandelbrot_raster_engine on a 2x1 raster with hand-computed pixel results.
// Also checks perf_cycles when MANDEL_PERF_CNT_EN is defined.
module tb_mandelbrot_raster_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic        pix_ready;
    logic [6:0]  max_ctr;
    logic [1:0]  scaling;
    logic [1:0]  ctr_select;
    logic [10:0] cr_offset;
    logic [10:0] ci_offset;
    logic        pix_valid;
    logic [3:0]  pix_data;
    logic        pix_last;
    logic        running;
    logic        finished;
`ifdef MANDEL_PERF_CNT_EN
    logic [31:0] perf_cycles;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mandelbrot_raster_engine #(
        .BITWIDTH(11), .CTRWIDTH(7), .OUTWIDTH(4), .COLS(2), .ROWS(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .run(run),
        .max_ctr(max_ctr), .scaling(scaling), .cr_offset(cr_offset),
        .ci_offset(ci_offset), .ctr_select(ctr_select), .pix_ready(pix_ready),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_last(pix_last),
        .running(running), .finished(finished)
`ifdef MANDEL_PERF_CNT_EN
        , .perf_cycles(perf_cycles)
`endif
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Called at a negedge while the engine is in IDLE; returns at the negedge after it latches.
    task automatic applyStimulus(input logic [10:0] cr, input logic [10:0] ci,
                                 input logic [6:0] mc, input logic [1:0] sc, input logic [1:0] cs);
        cr_offset  = cr;
        ci_offset  = ci;
        max_ctr    = mc;
        scaling    = sc;
        ctr_select = cs;
        pix_ready  = 1'b1;
        run        = 1'b1;
        @(negedge clk);
    endtask

    task automatic waitPixel(output int iters, output logic [3:0] data, output logic last);
        iters = 0;
        for (int i = 0; i < 300 && !pix_valid; i++) begin
            if (running) iters++;
            @(negedge clk);
        end
        if (!pix_valid) checkOutput("pixel_timeout", {31'b0, pix_valid}, 32'd1);
        data = pix_data;
        last = pix_last;
    endtask

    task automatic checkFrame(input string tag, input int exp_iters, input logic [3:0] exp_data);
        int         it;
        logic [3:0] d;
        logic       l;
        waitPixel(it, d, l);
        checkOutput({tag, "_iters0"}, it, exp_iters);
        checkOutput({tag, "_data0"}, {28'b0, d}, {28'b0, exp_data});
        checkOutput({tag, "_last0"}, {31'b0, l}, 32'd0);
        @(negedge clk);
        waitPixel(it, d, l);
        checkOutput({tag, "_iters1"}, it, exp_iters);
        checkOutput({tag, "_data1"}, {28'b0, d}, {28'b0, exp_data});
        checkOutput({tag, "_last1"}, {31'b0, l}, 32'd1);
        @(negedge clk);
        checkOutput({tag, "_finished"}, {31'b0, finished}, 32'd1);
        checkOutput({tag, "_stopped"}, {31'b0, running}, 32'd0);
    endtask

    task automatic endFrame();
        run = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int         it;
        logic [3:0] d;
        logic       l;
        logic [3:0] held;

        rst_n = 1'b1; run = 1'b0; pix_ready = 1'b1;
        max_ctr = '0; scaling = '0; ctr_select = '0; cr_offset = '0; ci_offset = '0;
        #1 rst_n = 1'b0;
        #2;
        checkOutput("rst_running", {31'b0, running}, 32'd0);
        checkOutput("rst_finished", {31'b0, finished}, 32'd0);
        checkOutput("rst_valid", {31'b0, pix_valid}, 32'd0);
        checkOutput("rst_data", {28'b0, pix_data}, 32'd0);
        checkOutput("rst_last", {31'b0, pix_last}, 32'd0);

        // c = 2.0: escapes after one update (count 1, two ITER cycles); later config edits must not matter
        cr_offset = 11'd512; ci_offset = 11'd0; max_ctr = 7'd10; run = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        #1 checkOutput("no_early_start", {31'b0, running}, 32'd0);
        @(negedge clk);
        checkOutput("started", {31'b0, running}, 32'd1);
        cr_offset = 11'd0; ci_offset = 11'd100; max_ctr = 7'd0; ctr_select = 2'd3;
        checkFrame("esc2", 2, 4'd1);
`ifdef MANDEL_PERF_CNT_EN
        checkOutput("perf_frame", perf_cycles, 32'd4);
`endif
        repeat (3) @(negedge clk);
        checkOutput("done_hold", {31'b0, finished}, 32'd1);
        checkOutput("done_no_restart", {31'b0, running}, 32'd0);
        run = 1'b0;
        @(negedge clk);
        checkOutput("done_to_idle", {31'b0, finished}, 32'd0);
        @(negedge clk);

        // c = 1.0: count 2 (three ITER cycles); second pixel c=257/256 also escapes at 2
        applyStimulus(11'd256, 11'd0, 7'd10, 2'd0, 2'd1);
        checkFrame("csel1", 3, 4'd1);
        endFrame();
        applyStimulus(11'd256, 11'd0, 7'd10, 2'd0, 2'd0);
        checkFrame("csel0", 3, 4'd2);
        endFrame();

        // Interior points run to max_ctr: 11 ITER cycles, data 0
        applyStimulus(11'd0, 11'd0, 7'd10, 2'd0, 2'd0);
        checkFrame("interior", 11, 4'd0);
        endFrame();

        // Backpressure in OUT
        applyStimulus(11'd512, 11'd0, 7'd10, 2'd0, 2'd0);
        pix_ready = 1'b0;
        waitPixel(it, d, l);
        held = d;
        checkOutput("stall_data0", {28'b0, d}, 32'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput("stall_valid", {31'b0, pix_valid}, 32'd1);
            checkOutput("stall_data", {28'b0, pix_data}, {28'b0, held});
            checkOutput("stall_last", {31'b0, pix_last}, 32'd0);
        end
        pix_ready = 1'b1;
        @(negedge clk);
        checkOutput("stall_release_valid", {31'b0, pix_valid}, 32'd0);
        checkOutput("stall_release_running", {31'b0, running}, 32'd1);
        waitPixel(it, d, l);
        checkOutput("stall_last1", {31'b0, l}, 32'd1);
        @(negedge clk);
        checkOutput("stall_finished", {31'b0, finished}, 32'd1);
        endFrame();

        // max_ctr=0: one ITER cycle per pixel; col 1 gives 1023+8 -> wraps to -1017 (raw 1031)
        applyStimulus(11'd1023, 11'd0, 7'd0, 2'd3, 2'd0);
        waitPixel(it, d, l);
        checkOutput("max0_iters0", it, 32'd1);
        checkOutput("max0_data0", {28'b0, d}, 32'd0);
        @(negedge clk);
        checkOutput("cr_wrap", {21'b0, dut.cr}, 32'd1031);
        waitPixel(it, d, l);
        checkOutput("max0_iters1", it, 32'd1);
        checkOutput("max0_last1", {31'b0, l}, 32'd1);
        @(negedge clk);
        endFrame();

        // run=0 during ITER aborts to IDLE next cycle; new frame restarts at col 0
        applyStimulus(11'd0, 11'd0, 7'd10, 2'd0, 2'd0);
        repeat (3) @(negedge clk);
        run = 1'b0;
        @(negedge clk);
        checkOutput("abort_iter_running", {31'b0, running}, 32'd0);
        checkOutput("abort_iter_valid", {31'b0, pix_valid}, 32'd0);
        applyStimulus(11'd512, 11'd0, 7'd10, 2'd0, 2'd0);
        checkFrame("after_abort", 2, 4'd1);
        endFrame();

        // run=0 during OUT completes the handshake, then IDLE
        applyStimulus(11'd512, 11'd0, 7'd10, 2'd0, 2'd0);
        pix_ready = 1'b0;
        waitPixel(it, d, l);
        run = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("abort_out_pending", {31'b0, pix_valid}, 32'd1);
        pix_ready = 1'b1;
        @(negedge clk);
        checkOutput("abort_out_running", {31'b0, running}, 32'd0);
        checkOutput("abort_out_valid", {31'b0, pix_valid}, 32'd0);
        applyStimulus(11'd512, 11'd0, 7'd10, 2'd0, 2'd0);
        checkFrame("after_out_abort", 2, 4'd1);
        endFrame();

        // Asynchronous reset between clock edges mid-ITER
        applyStimulus(11'd0, 11'd0, 7'd10, 2'd0, 2'd0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_running", {31'b0, running}, 32'd0);
        checkOutput("async_valid", {31'b0, pix_valid}, 32'd0);
        checkOutput("async_finished", {31'b0, finished}, 32'd0);
        checkOutput("async_data", {28'b0, pix_data}, 32'd0);
`ifdef MANDEL_PERF_CNT_EN
        checkOutput("async_perf", perf_cycles, 32'd0);
`endif
        cr_offset = 11'd512;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkFrame("after_reset", 2, 4'd1);
        endFrame();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mandelbrot_raster_engine.md
MANDELBROT_RASTER_ENGINE -- requirements
Module: mandelbrot_raster_engine

Interface
REQ-001 SHALL have parameter BITWIDTH, default 11: signed fixed-point width of c and z; FRAC = BITWIDTH-3 fractional bits.
REQ-002 SHALL have parameter CTRWIDTH, default 7: iteration counter width.
REQ-003 SHALL have parameter OUTWIDTH, default 4: pixel output width.
REQ-004 SHALL have parameters COLS, default 80, and ROWS, default 60: raster dimensions in pixels.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1: reset is asynchronous and active-low.
REQ-007 SHALL have port run, input, 1: frame start request / keep-running level.
REQ-008 SHALL have ports max_ctr (input, CTRWIDTH), scaling (input, 2), cr_offset (input, BITWIDTH), ci_offset (input, BITWIDTH) and ctr_select (input, 2), as frame configuration.
REQ-009 SHALL have port pix_ready, input, 1: downstream accepts a pixel.
REQ-010 SHALL have outputs pix_valid (1), pix_data (OUTWIDTH), pix_last (1), running (1) and finished (1).

Function
REQ-011 SHALL implement FSM states IDLE, ITER, OUT and DONE.
REQ-012 In IDLE with run=1, SHALL latch all configuration inputs, set col=0, row=0, z=0, n=0, and enter ITER; configuration changes after the latch SHALL be ignored until the next frame.
REQ-013 SHALL compute cr = cr_offset + col*2^scaling and ci = ci_offset + row*2^scaling, modulo 2^BITWIDTH (wrap, no saturation).
REQ-014 In each ITER cycle, SHALL escape if zr^2+zi^2 >= 4.0, evaluated on full-precision 2*BITWIDTH+1-bit products before truncation.
REQ-015 In ITER, on escape or n==max_ctr, SHALL enter OUT with count=n; otherwise it SHALL set zr=(zr^2-zi^2)>>>FRAC+cr, zi=(2*zr*zi)>>>FRAC+ci (truncated to BITWIDTH), and n=n+1.
REQ-016 Consequently a pixel SHALL spend n+1 ITER cycles; max_ctr=0 SHALL give exactly one ITER cycle.
REQ-017 pix_data SHALL be (count>>ctr_select)[OUTWIDTH-1:0] for escaped pixels, and 0 for non-escaped (interior) pixels.
REQ-018 In OUT, pix_valid=1; pix_data and pix_last SHALL be held stable until the cycle where pix_valid&&pix_ready.
REQ-019 On handshake, SHALL advance col (wrapping to 0 and incrementing row at COLS-1), reset z and n, and return to ITER.
REQ-020 pix_last SHALL be 1 only for col=COLS-1, row=ROWS-1; its handshake SHALL enter DONE.
REQ-021 running SHALL be 1 in ITER and OUT; finished SHALL be 1 in DONE only.
REQ-022 DONE SHALL remain until run=0, then enter IDLE; run=1 in DONE SHALL NOT restart.
REQ-023 run=0 in ITER SHALL enter IDLE next cycle; run=0 in OUT SHALL complete the pending handshake, then enter IDLE.

Reset
REQ-024 rst_n=0 SHALL immediately force IDLE, with pix_valid, pix_data, pix_last, running and finished at 0, and col, row, z, n and the latched configuration cleared, including mid-frame.
REQ-025 After rst_n deasserts, the first state change SHALL occur no earlier than the next clk rising edge.

Configuration
REQ-026 With MANDEL_PERF_CNT_EN defined, SHALL add output perf_cycles (32): the count of ITER cycles in the current frame, cleared at frame start, held through DONE/IDLE, saturating at all-ones.
REQ-027 Without MANDEL_PERF_CNT_EN, perf_cycles and its counter SHALL be absent; all other behaviour SHALL be identical.

Verification (BITWIDTH=11, FRAC=8, 1.0=256)
REQ-028 COLS=1, ROWS=1, cr=512 (2.0), ci=0, max_ctr=10, ctr_select=0, pix_ready=1 -> 2 ITER cycles, pix_data=1, pix_last=1, finished=1 next cycle; perf_cycles=2 if enabled.
REQ-029 cr=256 (1.0), ci=0, ctr_select=1 -> count=2, pix_data=1; with ctr_select=0 -> pix_data=2.
REQ-030 COLS=2, ROWS=1, cr=0, ci=0, max_ctr=10 -> each pixel spends 11 ITER cycles, pix_data=0; the second pixel has pix_last=1.
REQ-031 Hold pix_ready=0 for 5 cycles in OUT -> pix_valid=1 and pix_data unchanged for all 5 cycles, col unchanged; pix_ready=1 -> advance.
REQ-032 max_ctr=0 and cr_offset=1023 with scaling=3, COLS=2 -> one ITER cycle per pixel; the second pixel's cr wraps to -1017.
REQ-033 Assert rst_n=0 mid-ITER between clock edges -> all outputs 0 without a clock edge; after release with run=1, the frame restarts at col=0, row=0.
